inert_spi_resp: RTL and testbench

SPI responder that models the inertial sensor end of the link driven by the team's 16-bit SPI master and inertial interface. It accepts 16-bit command frames, services register writes and reads, snapshots externally supplied pitch-rate and AZ samples at a fixed output data rate, and raises INT when a new sample is ready. It sits in the testbench and FPGA self-test builds, in place of the physical sensor.

---
 rtl/inert_spi_resp.sv | 254 +++++++++++++++++++++++++
 tb/tb_inert_spi_resp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_spi_resp.sv
// inert_spi_resp: SPI responder standing in for the inertial sensor in bench
// and FPGA self-test builds. Takes 16-bit frames {R/W, addr[6:0], data[7:0]},
// serves a small register map, snapshots pitch-rate/AZ samples at a fixed
// output data rate and raises INT when a new sample is ready.
//
// Build option INERT_RESP_INT_LATCH_EN:
//   defined   -> INT latches until a read frame of 0x2D completes; ticks while
//                INT is high neither reload the snapshots nor re-raise INT.
//   undefined -> INT pulses for INT_PULSE_CYCLES after every enabled tick.
//
// state  | meaning
// IDLE   | waiting for SS_n fall
// CMD    | shifting the command byte (R/W + address)
// DATA   | shifting write data in, read data out on MISO
// COMMIT | one cycle after SS_n rise; write applied if the frame was complete
module inert_spi_resp #(
    parameter int         ODR_CYCLES       = 4096,
    parameter int         INT_PULSE_CYCLES = 64,
    parameter logic [7:0] WHO_AM_I_VAL     = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] az_in,
    output logic        setup_done
);

    localparam int              ODR_W    = $clog2(ODR_CYCLES);
    localparam logic [ODR_W-1:0] ODR_LAST = ODR_W'(ODR_CYCLES - 1);

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_CTRL5_C   = 7'h14;
    localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
    localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
    localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
    localparam logic [6:0] ADDR_AZ_H      = 7'h2D;

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ss_sync, sclk_sync, mosi_sync;
    logic              ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit;
    logic              start_frame, latch_cmd, commit, wr_en;
    logic [4:0]        bit_cnt;
    logic [15:0]       rx_shift;
    logic [7:0]        tx_shift;
    logic              miso_q;
    logic [6:0]        cmd_addr;
    logic [7:0]        rd_byte;
    logic [7:0]        int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5_c;
    logic              seen_0d, seen_14;
    logic [15:0]       ptch_snap, az_snap;
    logic [ODR_W-1:0]  odr_cnt;
    logic              tick, int_en, snap_en, int_q;

    // two-flop synchronizers plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b000;
            mosi_sync <= 3'b000;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    assign ss_fall   =  ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] &  ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign mosi_bit  = mosi_sync[2];

    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state and frame control strobes
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        latch_cmd   = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_rise) state_d = COMMIT;
                else if (ss_fall) begin
                    state_d     = CMD;
                    start_frame = 1'b1;
                end
            end
            CMD: begin
                if (ss_rise) state_d = COMMIT;
                else if (sclk_rise && bit_cnt == 5'd7) begin
                    latch_cmd = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (ss_rise) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // only a complete 16-rise write frame has side effects
    assign wr_en    = commit && (bit_cnt == 5'd16) && !rx_shift[15];
    assign cmd_addr = {rx_shift[5:0], mosi_bit};
    assign int_en   = int1_ctrl[1];

    // read byte lookup for the address arriving with the 8th rise
    always_comb begin
        rd_byte = 8'h00;
        case (cmd_addr)
            ADDR_INT1_CTRL: rd_byte = int1_ctrl;
            ADDR_WHO_AM_I:  rd_byte = WHO_AM_I_VAL;
            ADDR_CTRL1_XL:  rd_byte = ctrl1_xl;
            ADDR_CTRL2_G:   rd_byte = ctrl2_g;
            ADDR_CTRL5_C:   rd_byte = ctrl5_c;
            ADDR_PTCH_L:    rd_byte = ptch_snap[7:0];
            ADDR_PTCH_H:    rd_byte = ptch_snap[15:8];
            ADDR_AZ_L:      rd_byte = az_snap[7:0];
            ADDR_AZ_H:      rd_byte = az_snap[15:8];
            default:        rd_byte = 8'h00;
        endcase
    end

    // rise counting, MOSI shift-in, read byte latch and MISO shift-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 5'd0;
            rx_shift <= 16'h0000;
            tx_shift <= 8'h00;
            miso_q   <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_cnt  <= 5'd0;
                rx_shift <= 16'h0000;
            end else if (commit) begin
                bit_cnt  <= 5'd0;
            end else if (sclk_rise && (state_q == CMD || state_q == DATA)) begin
                rx_shift <= {rx_shift[14:0], mosi_bit};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (latch_cmd) tx_shift <= rx_shift[6] ? rd_byte : 8'h00;
            if (ss_rise || state_q == IDLE || state_q == COMMIT) begin
                miso_q <= 1'b0;
            end else if (state_q == DATA && sclk_fall) begin
                miso_q   <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // configuration registers and sticky setup tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl5_c   <= 8'h00;
            seen_0d   <= 1'b0;
            seen_14   <= 1'b0;
        end else if (wr_en) begin
            case (rx_shift[14:8])
                ADDR_INT1_CTRL: begin
                    int1_ctrl <= rx_shift[7:0];
                    seen_0d   <= 1'b1;
                end
                ADDR_CTRL1_XL: ctrl1_xl <= rx_shift[7:0];
                ADDR_CTRL2_G:  ctrl2_g  <= rx_shift[7:0];
                ADDR_CTRL5_C: begin
                    ctrl5_c <= rx_shift[7:0];
                    seen_14 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // free-running output data rate counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                odr_cnt <= '0;
        else if (odr_cnt == ODR_LAST) odr_cnt <= '0;
        else                       odr_cnt <= odr_cnt + ODR_W'(1);
    end

    assign tick = (odr_cnt == ODR_LAST);

`ifdef INERT_RESP_INT_LATCH_EN
    logic rd_2d;
    assign rd_2d   = commit && (bit_cnt == 5'd16) && rx_shift[15] && (rx_shift[14:8] == ADDR_AZ_H);
    assign snap_en = tick & int_en & ~int_q;

    // latched INT: a fresh sample wins over a same-cycle clearing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_q <= 1'b0;
        else begin
            if (rd_2d)   int_q <= 1'b0;
            if (snap_en) int_q <= 1'b1;
        end
    end
`else
    localparam int                PULSE_W    = $clog2(INT_PULSE_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(INT_PULSE_CYCLES - 1);
    logic [PULSE_W-1:0] int_cnt;
    assign snap_en = tick & int_en;

    // pulsed INT: down-counter holds INT for the pulse width, retriggered by each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q   <= 1'b0;
            int_cnt <= '0;
        end else if (snap_en) begin
            int_q   <= 1'b1;
            int_cnt <= PULSE_LAST;
        end else if (int_q) begin
            if (int_cnt == '0) int_q <= 1'b0;
            else               int_cnt <= int_cnt - PULSE_W'(1);
        end
    end
`endif

    // sample snapshot on enabled ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_snap <= 16'h0000;
            az_snap   <= 16'h0000;
        end else if (snap_en) begin
            ptch_snap <= ptch_rt_in;
            az_snap   <= az_in;
        end
    end

    assign MISO       = miso_q;
    assign INT        = int_q;
    assign setup_done = seen_0d & seen_14;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: SPI master stimulus (directed plus randomized
// frames), a register-map/timing model of the sensor, and a per-cycle compare
// of INT, setup_done and settled MISO. Honors INERT_RESP_INT_LATCH_EN.
module tb_inert_spi_resp;

    localparam int ODR   = 4096;
    localparam int PULSE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        INT;
    logic [15:0] ptch_rt_in = 16'h0000;
    logic [15:0] az_in = 16'h0000;
    logic        setup_done;

    always #5 clk = ~clk;

    inert_spi_resp #(.ODR_CYCLES(ODR), .INT_PULSE_CYCLES(PULSE), .WHO_AM_I_VAL(8'h6A)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .INT(INT), .ptch_rt_in(ptch_rt_in), .az_in(az_in), .setup_done(setup_done)
    );

    int checks = 0;
    int failures = 0;

    // model state: n = clk edges since reset release; pin actions land 3 edges later
    int          n = 0;
    logic [7:0]  m_rw [128];
    logic [15:0] m_ptch = 16'h0000, m_az = 16'h0000;
    logic        m_int = 1'b0, m_seen0d = 1'b0, m_seen14 = 1'b0;
    logic        m_snapped = 1'b0, m_block = 1'b0, int_armed = 1'b0;
    int          int_start = 0;
    logic [7:0]  m_latched = 8'h00;
    logic        rd_pend = 1'b0, cm_pend = 1'b0;
    int          rd_due = 0, cm_due = 0, cm_rises = 0;
    logic [15:0] rd_word = 16'h0000, cm_word = 16'h0000;
    logic        exp_miso = 1'b0;
    int          chg_n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_lookup(input logic [6:0] a);
        case (a)
            7'h0F: return 8'h6A;
            7'h0D, 7'h10, 7'h11, 7'h14: return m_rw[a];
            7'h22: return m_ptch[7:0];
            7'h23: return m_ptch[15:8];
            7'h2C: return m_az[7:0];
            7'h2D: return m_az[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // behavioural sensor model, evaluated once per clk edge
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; m_int = 0; int_armed = 0; int_start = 0;
            m_ptch = 0; m_az = 0; m_seen0d = 0; m_seen14 = 0;
            rd_pend = 0; cm_pend = 0;
            for (int i = 0; i < 128; i++) m_rw[i] = 8'h00;
        end else begin
            n++;
            if (rd_pend && n == rd_due) begin
                rd_pend   = 0;
                m_latched = rd_word[15] ? m_lookup(rd_word[14:8]) : 8'h00;
            end
`ifdef INERT_RESP_INT_LATCH_EN
            m_block = m_int;
`else
            m_block = 1'b0;
`endif
            m_snapped = 0;
            if (n % ODR == 0 && m_rw[7'h0D][1] && !m_block) begin
                m_ptch = ptch_rt_in; m_az = az_in;
                m_snapped = 1; int_armed = 1; int_start = n; m_int = 1;
            end
            if (cm_pend && n == cm_due) begin
                cm_pend = 0;
                if (cm_rises == 16 && !cm_word[15]) begin
                    case (cm_word[14:8])
                        7'h0D: begin m_rw[7'h0D] = cm_word[7:0]; m_seen0d = 1; end
                        7'h10: m_rw[7'h10] = cm_word[7:0];
                        7'h11: m_rw[7'h11] = cm_word[7:0];
                        7'h14: begin m_rw[7'h14] = cm_word[7:0]; m_seen14 = 1; end
                        default: ;
                    endcase
                end
`ifdef INERT_RESP_INT_LATCH_EN
                if (cm_rises == 16 && cm_word[15] && cm_word[14:8] == 7'h2D && !m_snapped) m_int = 0;
`endif
            end
`ifndef INERT_RESP_INT_LATCH_EN
            m_int = int_armed && (n - int_start < PULSE);
`endif
        end
    end

    // per-cycle compare, away from the active edge; MISO only once settled
    always @(negedge clk) begin
        if (rst_n) begin
            chk("INT", INT, m_int);
            chk("setup_done", setup_done, m_seen0d & m_seen14);
            if (n >= chg_n + 3) chk("MISO", MISO, exp_miso);
        end
    end

    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    // one SPI frame of nr rises; returns the data byte the master sampled
    task automatic spi_frame(input logic [15:0] w, input int nr, input int half,
                             output logic [7:0] rd, output logic cmd_or);
        rd = 8'h00;
        cmd_or = 1'b0;
        @(negedge clk);
        SS_n = 1'b0; MOSI = w[15]; exp_miso = 1'b0; chg_n = n;
        for (int i = 1; i <= nr; i++) begin
            wait_neg(half);
            if (i <= 8) cmd_or = cmd_or | MISO;
            if (i >= 9 && i <= 16) rd[16-i] = MISO;
            SCLK = 1'b1;
            if (i == 8) begin rd_pend = 1; rd_due = n + 3; rd_word = w; end
            wait_neg(half);
            SCLK = 1'b0;
            exp_miso = (i >= 8 && i <= 15) ? m_latched[15-i] : 1'b0;
            chg_n = n;
            MOSI = (i < 16) ? w[15-i] : 1'b0;
        end
        wait_neg(half);
        SS_n = 1'b1; MOSI = 1'b0; exp_miso = 1'b0; chg_n = n;
        cm_pend = 1; cm_due = n + 4; cm_word = w; cm_rises = nr;
        wait_neg(10);
    endtask

    task automatic rd_reg(input logic [7:0] cmd, output logic [7:0] v);
        logic cz;
        spi_frame({cmd, 8'h00}, 16, 6, v, cz);
    endtask

    task automatic wr_reg(input logic [15:0] w);
        logic [7:0] v;
        logic cz;
        spi_frame(w, 16, 6, v, cz);
    endtask

    task automatic wait_int(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 2 * ODR && !got; k++) begin
            @(negedge clk);
            if (INT) got = 1'b1;
        end
        chk(name, got, 1'b1);
    endtask

    initial begin
        logic [7:0] rd;
        logic cz, seen;
        logic [6:0] a;
        logic rwb;
        int nr, pick;

        repeat (4) @(negedge clk);
        chk("rst_MISO", MISO, 1'b0);
        chk("rst_INT", INT, 1'b0);
        chk("rst_setup_done", setup_done, 1'b0);
        rst_n = 1'b1;
        ptch_rt_in = 16'h1234;
        az_in = 16'hBEEF;
        wait_neg(5);

        spi_frame(16'h8F00, 16, 6, rd, cz);
        chk("who_am_i", rd, 8'h6A);
        chk("who_cmd_miso", cz, 1'b0);

        seen = 1'b0;
        repeat (3 * ODR) begin
            @(negedge clk);
            if (INT) seen = 1'b1;
        end
        chk("int_en0_no_int", seen, 1'b0);
        rd_reg(8'hA2, rd); chk("int_en0_ptch_l", rd, 8'h00);
        rd_reg(8'hA3, rd); chk("int_en0_ptch_h", rd, 8'h00);
        rd_reg(8'hAC, rd); chk("int_en0_az_l", rd, 8'h00);
        rd_reg(8'hAD, rd); chk("int_en0_az_h", rd, 8'h00);

        wr_reg(16'h0D02);
        chk("setup_after_0d", setup_done, 1'b0);
        wr_reg(16'h1053);
        wr_reg(16'h1050);
        wr_reg(16'h1460);
        chk("setup_after_14", setup_done, 1'b1);
        rd_reg(8'h8D, rd); chk("rd_int1_ctrl", rd, 8'h02);
        rd_reg(8'h90, rd); chk("rd_ctrl1_xl", rd, 8'h50);
        rd_reg(8'h94, rd); chk("rd_ctrl5_c", rd, 8'h60);

        wait_int("wait_int_data");
        rd_reg(8'hA2, rd); chk("ptch_l", rd, 8'h34);
        rd_reg(8'hA3, rd); chk("ptch_h", rd, 8'h12);
        rd_reg(8'hAC, rd); chk("az_l", rd, 8'hEF);
        rd_reg(8'hAD, rd); chk("az_h", rd, 8'hBE);

`ifdef INERT_RESP_INT_LATCH_EN
        ptch_rt_in = 16'h5678; az_in = 16'h1357;
        wait_int("latch_wait_first");
        ptch_rt_in = 16'h9ABC; az_in = 16'h2468;
        wait_neg(2 * ODR + 16);
        chk("latch_int_held", INT, 1'b1);
        rd_reg(8'hA2, rd); chk("latch_old_ptch_l", rd, 8'h78);
        rd_reg(8'hAD, rd); chk("latch_old_az_h", rd, 8'h13);
        wait_int("latch_wait_reload");
        rd_reg(8'hA2, rd); chk("latch_new_ptch_l", rd, 8'hBC);
`endif

        spi_frame(16'h1077, 12, 6, rd, cz);
        rd_reg(8'h90, rd); chk("abort_keeps_0x10", rd, 8'h50);
        rd_reg(8'h8F, rd); chk("abort_then_who", rd, 8'h6A);

        for (int f = 0; f < 40; f++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: a = 7'h0D;
                1: a = 7'h0F;
                2: a = 7'h10;
                3: a = 7'h11;
                4: a = 7'h14;
                5: a = 7'h22;
                6: a = 7'h23;
                7: a = 7'h2C;
                8: a = 7'h2D;
                default: a = 7'($urandom);
            endcase
            rwb = 1'($urandom);
            nr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : 16;
            if ($urandom_range(0, 1) == 1) begin
                ptch_rt_in = 16'($urandom);
                az_in = 16'($urandom);
            end
            spi_frame({rwb, a, 8'($urandom)}, nr, int'($urandom_range(4, 7)), rd, cz);
            chk("rand_cmd_miso", cz, 1'b0);
            if (nr == 16 && rwb) chk("rand_rd", rd, m_latched);
            wait_neg(int'($urandom_range(0, 400)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
